// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed-latency response channel.
// Single reads and writes return one beat; read bursts return four consecutive words.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic        req_burst,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_last
);

  localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [2:0]  LatLoad = 3'(LATENCY - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]  state_q, state_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic [1:0]  beat_q, beat_d;
  logic [29:0] base_q, base_d;
  logic        misal_q, misal_d;
  logic        we_q, we_d;
  logic        burst_q, burst_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        last_q, last_d;

  // Source fields of the beat being launched on this edge.
  logic        load_beat;
  logic [29:0] src_base;
  logic        src_misal;
  logic        src_we;
  logic        src_burst;
  logic [1:0]  src_beat;

  logic [31:0] beat_idx;
  logic        beat_err;
  logic        beat_is_last;
  logic [31:0] mem_rdata;
  logic        accept;
  logic        mem_we;

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign rsp_last  = last_q;

  assign accept = req_valid & req_ready;

  // A write commits on acceptance only if it is a legal single, aligned, in-range access.
  assign mem_we = accept & req_we & ~req_burst & ~(|req_addr[1:0])
                & ({2'b00, req_addr[31:2]} < DEPTH_WORDS);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[req_addr[AW+1:2]] <= req_wdata;
    end
  end

  assign beat_idx     = {2'b00, src_base} + {30'd0, src_beat};
  assign beat_err     = src_misal | (beat_idx >= DEPTH_WORDS) | (src_we & src_burst);
  assign beat_is_last = (src_burst & ~src_we) ? (src_beat == 2'd3) : 1'b1;
  assign mem_rdata    = mem[beat_idx[AW-1:0]];

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    beat_d    = beat_q;
    base_d    = base_q;
    misal_d   = misal_q;
    we_d      = we_q;
    burst_d   = burst_q;

    load_beat = 1'b0;
    src_base  = base_q;
    src_misal = misal_q;
    src_we    = we_q;
    src_burst = burst_q;
    src_beat  = 2'd0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          base_d    = req_addr[31:2];
          misal_d   = |req_addr[1:0];
          we_d      = req_we;
          burst_d   = req_burst;
          lat_cnt_d = LatLoad;
          beat_d    = 2'd0;
          if (LATENCY > 1) begin
            state_d = StWait;
          end else begin
            // Zero wait states: launch beat 0 straight from the request.
            state_d   = StResp;
            load_beat = 1'b1;
            src_base  = req_addr[31:2];
            src_misal = |req_addr[1:0];
            src_we    = req_we;
            src_burst = req_burst;
          end
        end
      end
      StWait: begin
        lat_cnt_d = lat_cnt_q - 3'd1;
        if (lat_cnt_q <= 3'd1) begin
          state_d   = StResp;
          lat_cnt_d = 3'd0;
          load_beat = 1'b1;
        end
      end
      StResp: begin
        if (last_q) begin
          state_d = StIdle;
          beat_d  = 2'd0;
        end else begin
          beat_d    = beat_q + 2'd1;
          src_beat  = beat_q + 2'd1;
          load_beat = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    rdata_d = 32'd0;
    err_d   = 1'b0;
    last_d  = 1'b0;
    if (load_beat) begin
      rdata_d = (beat_err | src_we) ? 32'd0 : mem_rdata;
      err_d   = beat_err;
      last_d  = beat_is_last;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      lat_cnt_q <= 3'd0;
      beat_q    <= 2'd0;
      base_q    <= 30'd0;
      misal_q   <= 1'b0;
      we_q      <= 1'b0;
      burst_q   <= 1'b0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      misal_q   <= misal_d;
      we_q      <= we_d;
      burst_q   <= burst_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      last_q    <= last_d;
    end
  end

endmodule
